// File: rtl/matmul_pkg.sv
// matmul_pkg: shared definitions for the matrix-multiplication engine slice.
// Holds the engine word width, the memory-port operation encodings used
// between the engine and its bus bridge, the bridge state encoding and a
// small saturating-increment helper for the bridge's activity counters.
package matmul_pkg;

    // Engine word width.
    localparam int TYPE_BW = 32;

    // Memory-port operation encodings driven by the engine (2'b10 is reserved).
    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b11;

    // Bridge FSM states.
    typedef enum logic [1:0] {
        BR_IDLE = 2'b00,
        BR_BUS  = 2'b01,
        BR_DONE = 2'b10,
        BR_HOLD = 2'b11
    } bridge_state_e;

    // Increment a 16-bit counter, sticking at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/matmul_wb_bridge.sv
// matmul_wb_bridge: Wishbone classic master for the matmul engine memory port.
// Each engine request (mem_operation/mem_addr/mem_wdata) becomes one
// single-word Wishbone cycle; completion is reported by a one-cycle
// mem_opdone, followed by a HOLD cycle that gives the engine time to update
// or withdraw its request. A bus timeout and slave errors set a sticky
// bus_error that clear_err removes.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   mem_operation/addr/wdata    - engine request (00 none, 01 read, 11 write)
//   mem_rdata, mem_opdone       - read data and completion pulse
//   wb_cyc_o..wb_dat_o          - registered Wishbone master outputs
//   wb_dat_i, wb_ack_i, wb_err_i- Wishbone slave response
//   bus_error, clear_err        - sticky error flag and its clear
//   rd_count, wr_count          - saturating completed-transfer counters
module matmul_wb_bridge
    import matmul_pkg::*;
#(
    parameter int          DATA_W    = TYPE_BW,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_operation,
    input  logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_opdone,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [3:0]        wb_sel_o,
    output logic [31:0]       wb_adr_o,
    output logic [31:0]       wb_dat_o,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    output logic              bus_error,
    input  logic              clear_err,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    // Last BUS cycle index before the timeout fires (timer starts at 0).
    localparam logic [9:0] TIMER_LAST = 10'(TIMEOUT - 1);

    bridge_state_e state_r;
    bridge_state_e next_state_s;
    logic          issue_s;
    logic          ack_ok_s;
    logic          fail_s;
    logic [9:0]    timer_r;
    logic [31:0]   wdata_ext_s;
    logic [31:0]   adr_next_s;
    logic          addr_hi_unused_s;

    // Word address to byte address; the top two word-address bits fall off.
    assign adr_next_s       = BASE_ADDR + {mem_addr[29:0], 2'b00};
    assign wdata_ext_s      = 32'(mem_wdata);
    assign addr_hi_unused_s = ^mem_addr[31:30];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= BR_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and per-cycle event strobes.
    always_comb begin
        next_state_s = state_r;
        issue_s      = 1'b0;
        ack_ok_s     = 1'b0;
        fail_s       = 1'b0;
        case (state_r)
            BR_IDLE: begin
                if ((mem_operation == MEM_READ) || (mem_operation == MEM_WRITE)) begin
                    next_state_s = BR_BUS;
                    issue_s      = 1'b1;
                end else begin
                    next_state_s = BR_IDLE;
                end
            end
            BR_BUS: begin
                // err takes precedence over a simultaneous ack
                if (wb_err_i) begin
                    next_state_s = BR_DONE;
                    fail_s       = 1'b1;
                end else if (wb_ack_i) begin
                    next_state_s = BR_DONE;
                    ack_ok_s     = 1'b1;
                end else if (timer_r == TIMER_LAST) begin
                    next_state_s = BR_DONE;
                    fail_s       = 1'b1;
                end else begin
                    next_state_s = BR_BUS;
                end
            end
            BR_DONE: begin
                next_state_s = BR_HOLD;
            end
            BR_HOLD: begin
                next_state_s = BR_IDLE;
            end
            default: begin
                next_state_s = BR_IDLE;
            end
        endcase
    end

    // Registered Wishbone outputs, engine handshake, timer, counters, error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_sel_o   <= 4'h0;
            wb_adr_o   <= 32'h0000_0000;
            wb_dat_o   <= 32'h0000_0000;
            mem_opdone <= 1'b0;
            mem_rdata  <= '0;
            timer_r    <= 10'd0;
            rd_count   <= 16'd0;
            wr_count   <= 16'd0;
            bus_error  <= 1'b0;
        end else begin
            // Outputs follow the state being entered so they are stable for the whole cycle.
            wb_cyc_o   <= (next_state_s == BR_BUS);
            wb_stb_o   <= (next_state_s == BR_BUS);
            wb_sel_o   <= (next_state_s == BR_BUS) ? 4'hF : 4'h0;
            mem_opdone <= (next_state_s == BR_DONE);

            if (issue_s) begin
                wb_adr_o <= adr_next_s;
                wb_dat_o <= wdata_ext_s;
                wb_we_o  <= mem_operation[1];
            end else if (next_state_s != BR_BUS) begin
                wb_we_o  <= 1'b0;
            end else begin
                wb_we_o  <= wb_we_o;
            end

            if (state_r == BR_BUS) begin
                timer_r <= timer_r + 10'd1;
            end else begin
                timer_r <= 10'd0;
            end

            if (ack_ok_s) begin
                if (wb_we_o) begin
                    wr_count <= sat_inc16(wr_count);
                end else begin
                    rd_count  <= sat_inc16(rd_count);
                    mem_rdata <= wb_dat_i[DATA_W-1:0];
                end
            end else if (fail_s) begin
                mem_rdata <= '0;
            end else begin
                mem_rdata <= mem_rdata;
            end

            // A new error outranks a clear in the same cycle.
            if (fail_s) begin
                bus_error <= 1'b1;
            end else if (clear_err) begin
                bus_error <= 1'b0;
            end else begin
                bus_error <= bus_error;
            end
        end
    end

endmodule

// File: tb/tb_matmul_wb_bridge.sv
// tb_matmul_wb_bridge: self-checking bench for matmul_wb_bridge.
// Directed steps plus a randomized transaction loop, each compared against a
// transaction-level model (expected byte address, cycle length, read data,
// counters and error flag) kept in this file. A simple Wishbone slave process
// answers with a programmable wait count and response kind.
module tb_matmul_wb_bridge;

    localparam int          TMO   = 8;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam logic [1:0]  OP_NO = 2'b00;
    localparam logic [1:0]  OP_RD = 2'b01;
    localparam logic [1:0]  OP_WR = 2'b11;
    localparam logic [1:0]  OP_RS = 2'b10;

    logic        clk;
    logic        reset;
    logic [1:0]  mem_operation;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_opdone;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        bus_error;
    logic        clear_err;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    // slave control: mode 0 ack, 1 err, 2 ack+err, 3 silent
    int          sl_wait;
    int          sl_mode;
    logic [31:0] sl_data;
    int          sl_cnt;

    // reference model state
    int          rd_exp;
    int          wr_exp;
    logic [31:0] rdata_exp;
    logic        err_exp;

    int checks;
    int errors;

    matmul_wb_bridge #(
        .DATA_W   (32),
        .BASE_ADDR(BASE),
        .TIMEOUT  (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_operation(mem_operation),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_opdone   (mem_opdone),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_we_o      (wb_we_o),
        .wb_sel_o     (wb_sel_o),
        .wb_adr_o     (wb_adr_o),
        .wb_dat_o     (wb_dat_o),
        .wb_dat_i     (wb_dat_i),
        .wb_ack_i     (wb_ack_i),
        .wb_err_i     (wb_err_i),
        .bus_error    (bus_error),
        .clear_err    (clear_err),
        .rd_count     (rd_count),
        .wr_count     (wr_count)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Wishbone slave: responds on the (sl_wait+1)-th cycle of an active strobe.
    initial begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'h0;
        sl_cnt   = 0;
        forever begin
            @(negedge clk);
            if (wb_cyc_o && wb_stb_o) begin
                if ((sl_cnt == sl_wait) && (sl_mode != 3)) begin
                    wb_ack_i = (sl_mode == 0) || (sl_mode == 2);
                    wb_err_i = (sl_mode == 1) || (sl_mode == 2);
                    wb_dat_i = sl_data;
                end else begin
                    wb_ack_i = 1'b0;
                    wb_err_i = 1'b0;
                end
                sl_cnt++;
            end else begin
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                sl_cnt   = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One engine request through completion and HOLD, checked against the model.
    task automatic do_txn(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input int wt, input int md, input logic clr);
        logic [31:0] exp_adr;
        int          cyc_len;
        int          exp_len;
        bit          seen;
        exp_adr = BASE + addr * 32'd4;
        exp_len = (md == 3) ? TMO : wt + 1;
        sl_wait = wt;
        sl_mode = md;
        sl_data = $urandom;
        @(negedge clk);
        mem_operation = op;
        mem_addr      = addr;
        mem_wdata     = wd;
        @(negedge clk);
        mem_operation = OP_NO;
        clear_err     = clr;
        chk("cyc_after_edge0", 32'(wb_cyc_o), 32'd1);
        chk("stb_after_edge0", 32'(wb_stb_o), 32'd1);
        chk("sel_in_cycle", 32'(wb_sel_o), 32'hF);
        chk("adr", wb_adr_o, exp_adr);
        chk("we", 32'(wb_we_o), 32'(op[1]));
        if (op == OP_WR) chk("dat_o", wb_dat_o, wd);
        cyc_len = 0;
        seen    = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (mem_opdone) begin
                seen = 1'b1;
                break;
            end
            if (wb_cyc_o) cyc_len++;
            @(negedge clk);
        end
        clear_err = 1'b0;
        if (md == 0) begin
            if (op == OP_RD) begin
                rd_exp++;
                rdata_exp = sl_data;
            end else begin
                wr_exp++;
            end
        end else begin
            rdata_exp = 32'h0;
            err_exp   = 1'b1;
        end
        chk("opdone_seen", 32'(seen), 32'd1);
        chk("cyc_length", 32'(cyc_len), 32'(exp_len));
        chk("cyc_low_at_done", 32'(wb_cyc_o), 32'd0);
        chk("rdata", mem_rdata, rdata_exp);
        chk("rd_count", 32'(rd_count), 32'(rd_exp));
        chk("wr_count", 32'(wr_count), 32'(wr_exp));
        chk("bus_error", 32'(bus_error), 32'(err_exp));
        @(negedge clk);
        chk("opdone_one_cycle", 32'(mem_opdone), 32'd0);
        chk("rdata_held", mem_rdata, rdata_exp);
    endtask

    initial begin
        int nd;
        int ncyc;
        int gap;
        logic prev;
        checks        = 0;
        errors        = 0;
        rd_exp        = 0;
        wr_exp        = 0;
        rdata_exp     = 32'h0;
        err_exp       = 1'b0;
        sl_wait       = 0;
        sl_mode       = 0;
        sl_data       = 32'h0;
        reset         = 1'b1;
        mem_operation = OP_NO;
        mem_addr      = 32'h0;
        mem_wdata     = 32'h0;
        clear_err     = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_we", 32'(wb_we_o), 32'd0);
        chk("rst_sel", 32'(wb_sel_o), 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_opdone", 32'(mem_opdone), 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_err", 32'(bus_error), 32'd0);
        chk("rst_counts", {rd_count, wr_count}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // zero-wait read of word 3
        do_txn(OP_RD, 32'd3, 32'h0, 0, 0, 1'b0);
        // write of word 0x10 with three wait states
        do_txn(OP_WR, 32'h10, 32'h55, 3, 0, 1'b0);

        // held read with address stepping 0..4
        sl_wait = 0;
        sl_mode = 0;
        sl_data = 32'h1234_5678;
        @(negedge clk);
        mem_operation = OP_RD;
        mem_addr      = 32'd0;
        nd   = 0;
        ncyc = 0;
        gap  = 0;
        prev = 1'b0;
        for (int i = 0; i < 80 && nd < 5; i++) begin
            @(negedge clk);
            if (wb_cyc_o && !prev) begin
                chk("held_adr", wb_adr_o, BASE + 32'(ncyc * 4));
                if (ncyc > 0) chk("held_gap", 32'(gap), 32'd3);
                ncyc++;
            end
            if (wb_cyc_o) gap = 0;
            else gap++;
            if (mem_opdone) begin
                nd++;
                rd_exp++;
                rdata_exp = sl_data;
                mem_addr  = 32'(nd);
                if (nd == 5) mem_operation = OP_NO;
            end
            prev = wb_cyc_o;
        end
        chk("held_done_pulses", 32'(nd), 32'd5);
        chk("held_cycles", 32'(ncyc), 32'd5);
        chk("held_rd_count", 32'(rd_count), 32'(rd_exp));
        repeat (5) @(negedge clk);
        chk("held_no_extra", 32'(wb_cyc_o), 32'd0);

        // timeout with a silent slave
        do_txn(OP_RD, 32'h22, 32'h0, 0, 3, 1'b0);
        repeat (5) @(negedge clk);
        chk("err_sticky", 32'(bus_error), 32'd1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        err_exp   = 1'b0;
        chk("err_cleared", 32'(bus_error), 32'd0);

        // reserved op is ignored
        mem_operation = OP_RS;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("reserved_no_cyc", {30'd0, wb_cyc_o, mem_opdone}, 32'd0);
        end
        mem_operation = OP_NO;
        chk("reserved_no_err", 32'(bus_error), 32'd0);

        // ack and err together count as an error
        do_txn(OP_RD, 32'h7, 32'h0, 1, 2, 1'b0);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        err_exp   = 1'b0;
        // error in the same cycle as clear_err: error wins
        do_txn(OP_WR, 32'h9, 32'hCAFE, 0, 1, 1'b1);

        // reset in the middle of a bus cycle
        sl_mode = 3;
        @(negedge clk);
        mem_operation = OP_WR;
        mem_addr      = 32'h40;
        @(negedge clk);
        mem_operation = OP_NO;
        @(negedge clk);
        chk("pre_reset_cyc", 32'(wb_cyc_o), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("midrst_stb", 32'(wb_stb_o), 32'd0);
        chk("midrst_opdone", 32'(mem_opdone), 32'd0);
        chk("midrst_err", 32'(bus_error), 32'd0);
        chk("midrst_counts", {rd_count, wr_count}, 32'd0);
        rd_exp    = 0;
        wr_exp    = 0;
        rdata_exp = 32'h0;
        err_exp   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_opdone", 32'(mem_opdone), 32'd0);
        end
        do_txn(OP_RD, 32'h15, 32'h0, 2, 0, 1'b0);

        // randomized acked transfers
        for (int i = 0; i < 12; i++) begin
            do_txn(($urandom_range(0, 1) == 0) ? OP_RD : OP_WR, $urandom, $urandom,
                   int'($urandom_range(0, 4)), 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
